unit_lower_inverse: RTL and testbench
=====================================

UNIT_LOWER_INVERSE -- requirements
Module: unit_lower_inverse

Interface
REQ-001 Parameter N, default 3: matrix dimension, N >= 2.
REQ-002 Parameter W, default 8: element width, signed two's complement.
REQ-003 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port start, input, 1: request; sampled only in IDLE.
REQ-006 Port L_in, input, W*N*N: unit lower triangular L from the LDL factorization stage; element (i,j) at bits W*(i*N+j) +: W.
REQ-007 Port busy, output, 1: high from the cycle after start is accepted until done asserts.
REQ-008 Port done, output, 1: single-cycle pulse when Linv_out is valid.
REQ-009 Port Linv_out, output, W*N*N: X = L^-1, packed the same way as L_in.

Function
REQ-010 The block SHALL compute X = L^-1 by column-wise forward substitution: X[i][i] = 1, X[i][j] = 0 for j > i, and X[i][j] = -sum over k = j..i-1 of L[i][k]*X[k][j] for i > j.
REQ-011 The block SHALL ignore the diagonal and upper triangle of L_in, treating each diagonal element as 1.
REQ-012 The block SHALL capture L_in into an internal register on the edge that accepts start; later changes to L_in SHALL NOT affect the result.
REQ-013 The block SHALL implement FSM IDLE -> LOAD -> ACC <-> WRITE -> DONE -> IDLE, as follows:
- LOAD: 1 cycle.
- ACC: 1 multiply-accumulate per cycle, (i-j) cycles per element.
- WRITE: 1 cycle per element; stores the negated, narrowed accumulator.
- DONE: 1 cycle; pulses done.
REQ-014 The block SHALL visit elements in order j = 0..N-2 outer, i = j+1..N-1 inner.
REQ-015 Latency: done SHALL rise exactly 1+M+E cycles after the edge that accepts start, where M = N(N-1)(N+1)/6 and E = N(N-1)/2 (N=3: 8 cycles).
REQ-016 The accumulator SHALL be 2W+$clog2(N) bits signed, cleared at the start of each element.
REQ-017 The block SHALL ignore start while busy or in DONE, with no effect on the computation.
REQ-018 Linv_out SHALL hold its value from done until the WRITE of the first element of the next run.
REQ-019 Linv_out SHALL hold 1 on every diagonal element and 0 on every upper-triangle element at all times after reset.
REQ-020 A start held high continuously SHALL begin a new run on the cycle after DONE returns to IDLE.

Reset
REQ-021 rst SHALL force IDLE, busy=0, done=0, Linv_out=identity, and accumulator and counters to 0, immediately and asynchronously.
REQ-022 rst asserted mid-run SHALL abort the run, with no done pulse produced.

Configuration
REQ-023 With macro UNIT_LOWER_INVERSE_SAT_EN defined, WRITE SHALL saturate to [-2^(W-1), 2^(W-1)-1].
REQ-024 Without UNIT_LOWER_INVERSE_SAT_EN, WRITE SHALL truncate to the low W bits (wrap).

Structure
REQ-025 Package ldl_pkg SHALL hold:
- the FSM state enum;
- localparams for M, E and latency as functions of N;
- a function computing the packed bit offset of element (i,j).
REQ-026 One sub-module, ldl_mac, SHALL contain the signed W x W multiplier, the accumulator, and the narrowing (saturate or wrap) logic.

Verification
REQ-027 N=3, W=8, L = identity, start -> done at cycle 8, Linv_out = identity.
REQ-028 L10=2, L20=3, L21=4, start -> X10=-2, X21=-4, X20=5; busy high for cycles 1..7.
REQ-029 L10=-100, L20=0, L21=100, start -> X10=100, X20=-128 with UNIT_LOWER_INVERSE_SAT_EN, X20=-16 without it.
REQ-030 start pulsed again at cycle 3 of a run, with L_in changed at cycle 2 -> single done at cycle 8, result from the originally captured L.
REQ-031 rst asserted at cycle 4 -> busy=0 and Linv_out=identity immediately, no done pulse; next start completes normally.

Source files
------------

// File: rtl/ldl_pkg.sv
// Shared types and helpers for the unit-lower-triangular inverse block.
// Latency helpers are parameterised on the matrix dimension n.
package ldl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACC,
    S_WRITE,
    S_DONE
  } state_e;

  function automatic int mac_cycles(input int n);
    return n * (n - 1) * (n + 1) / 6;
  endfunction

  function automatic int elem_count(input int n);
    return n * (n - 1) / 2;
  endfunction

  function automatic int latency(input int n);
    return 1 + mac_cycles(n) + elem_count(n);
  endfunction

  localparam int N_DEF   = 3;
  localparam int M_DEF   = mac_cycles(N_DEF);
  localparam int E_DEF   = elem_count(N_DEF);
  localparam int LAT_DEF = latency(N_DEF);

  // Bit offset of element (i,j) in a row-major packed n x n matrix.
  function automatic int elem_off(
    input int n,
    input int w,
    input int i,
    input int j
  );
    return w * (i * n + j);
  endfunction

endpackage

// File: rtl/ldl_mac.sv
// Signed multiply-accumulate with negate-and-narrow output stage.
// Define UNIT_LOWER_INVERSE_SAT_EN to saturate instead of wrapping.
module ldl_mac #(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] q_o
);

  localparam int AW = 2 * W + $clog2(N);

  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  acc_q;
  logic signed [AW-1:0]  acc_d;

  assign prod = (2*W)'(a_i) * (2*W)'(b_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + AW'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef UNIT_LOWER_INVERSE_SAT_EN
  logic signed [AW-1:0] neg;
  logic                 ovf;

  assign neg = -acc_q;
  // Fits in W bits only if all bits above the W-bit sign agree with it.
  assign ovf = ~(&neg[AW-1:W-1]) & (|neg[AW-1:W-1]);

  always_comb begin
    q_o = neg[W-1:0];
    if (ovf) begin
      q_o = neg[AW-1] ? {1'b1, {(W-1){1'b0}}}
                      : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign q_o = -acc_q[W-1:0];
`endif

endmodule

// File: rtl/unit_lower_inverse.sv
// Inverse of a unit lower triangular matrix by column-wise forward
// substitution; UNIT_LOWER_INVERSE_SAT_EN selects saturating writes.
module unit_lower_inverse
  import ldl_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W*N*N-1:0] L_in,
  output logic             busy,
  output logic             done,
  output logic [W*N*N-1:0] Linv_out
);

  localparam int NB = W * N * N;
  localparam int CW = $clog2(N);

  function automatic logic [NB-1:0] ident_f();
    logic [NB-1:0] r;
    r = '0;
    for (int d = 0; d < N; d++) begin
      r[elem_off(N, W, d, d) +: W] = {{(W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  localparam logic [NB-1:0] IDENT = ident_f();

  state_e              st_q;
  logic [NB-1:0]       l_q;
  logic [NB-1:0]       x_q;
  logic [CW-1:0]       i_q;
  logic [CW-1:0]       j_q;
  logic [CW-1:0]       k_q;
  logic signed [W-1:0] mac_a;
  logic signed [W-1:0] mac_b;
  logic signed [W-1:0] mac_q;
  logic                mac_en;
  logic                mac_clr;

  // X[j][j] is implicitly 1; other X[k][j] were written earlier this column.
  always_comb begin
    mac_a = l_q[elem_off(N, W, int'(i_q), int'(k_q)) +: W];
    mac_b = x_q[elem_off(N, W, int'(k_q), int'(j_q)) +: W];
    if (k_q == j_q) begin
      mac_b = {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign mac_en  = (st_q == S_ACC);
  assign mac_clr = (st_q == S_WRITE) || (st_q == S_LOAD);

  ldl_mac #(
    .N(N),
    .W(W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr_i(mac_clr),
    .en_i (mac_en),
    .a_i  (mac_a),
    .b_i  (mac_b),
    .q_o  (mac_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      l_q  <= '0;
      x_q  <= IDENT;
      i_q  <= '0;
      j_q  <= '0;
      k_q  <= '0;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (start) begin
            l_q  <= L_in;
            st_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          j_q  <= '0;
          i_q  <= CW'(1);
          k_q  <= '0;
          busy <= 1'b1;
          st_q <= S_ACC;
        end
        S_ACC: begin
          if (k_q == i_q - CW'(1)) begin
            st_q <= S_WRITE;
          end else begin
            k_q <= k_q + CW'(1);
          end
        end
        S_WRITE: begin
          x_q[elem_off(N, W, int'(i_q), int'(j_q)) +: W] <= mac_q;
          if (i_q == CW'(N - 1)) begin
            if (j_q == CW'(N - 2)) begin
              busy <= 1'b0;
              done <= 1'b1;
              st_q <= S_DONE;
            end else begin
              j_q  <= j_q + CW'(1);
              i_q  <= j_q + CW'(2);
              k_q  <= j_q + CW'(1);
              st_q <= S_ACC;
            end
          end else begin
            i_q  <= i_q + CW'(1);
            k_q  <= j_q;
            st_q <= S_ACC;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          st_q <= S_IDLE;
        end
        default: begin
          st_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Linv_out = x_q;

endmodule

// File: tb/tb_unit_lower_inverse.sv
// Scoreboard bench for unit_lower_inverse (N=3, W=8).
// Directed runs push expected inverses; a monitor checks on each done.
module tb_unit_lower_inverse;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int NB = W * N * N;
  localparam int LAT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NB-1:0] L_in;
  logic          busy;
  logic          done;
  logic [NB-1:0] Linv_out;

  typedef struct {
    logic [NB-1:0] x;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  unit_lower_inverse #(
    .N(N),
    .W(W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .L_in    (L_in),
    .busy    (busy),
    .done    (done),
    .Linv_out(Linv_out)
  );

  function automatic logic [NB-1:0] pk(
    input logic [7:0] d, u, l10, l20, l21
  );
    logic [NB-1:0] r;
    r = '0;
    r[0 +: 8]  = d;
    r[8 +: 8]  = u;
    r[16 +: 8] = u;
    r[24 +: 8] = l10;
    r[32 +: 8] = d;
    r[40 +: 8] = u;
    r[48 +: 8] = l20;
    r[56 +: 8] = l21;
    r[64 +: 8] = d;
    return r;
  endfunction

  function automatic void chk(
    input string nm, input logic [NB-1:0] a, input logic [NB-1:0] e
  );
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endfunction

  function automatic void chk_i(input string nm, input int a, input int e);
    n_vec++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", nm, a, e);
    end
  endfunction

  // Monitor: every done must match the oldest pending expectation.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done_unexpected cyc=%0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("result", Linv_out, e.x);
        chk_i("latency", cyc - e.acc, LAT);
      end
    end
  end

  task automatic go(input logic [NB-1:0] l, input logic [NB-1:0] x,
                    input bit expect_it);
    exp_t e;
    @(negedge clk);
    L_in  = l;
    start = 1'b1;
    if (expect_it) begin
      e.x   = x;
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string nm, input int maxc);
    int c;
    c = 0;
    while (sb.size() != 0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s timeout pending=%0d", nm, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  logic [NB-1:0] id_m, x2, x3, x6, l2;

  initial begin
    exp_t e;
    int   t;
    id_m = pk(8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    l2   = pk(8'h07, 8'h55, 8'd2, 8'd3, 8'd4);
    x2   = pk(8'd1, 8'd0, 8'hFE, 8'h05, 8'hFC);
`ifdef UNIT_LOWER_INVERSE_SAT_EN
    x3   = pk(8'd1, 8'd0, 8'h64, 8'h80, 8'h9C);
`else
    x3   = pk(8'd1, 8'd0, 8'h64, 8'hF0, 8'h9C);
`endif
    x6   = pk(8'd1, 8'd0, 8'hFF, 8'h00, 8'hFF);

    rst   = 1'b1;
    start = 1'b0;
    L_in  = '0;
    #12;
    chk("rst_busy", NB'(busy), NB'(0));
    chk("rst_done", NB'(done), NB'(0));
    chk("rst_linv", Linv_out, id_m);
    @(negedge clk);
    rst = 1'b0;

    go(id_m, id_m, 1'b1);
    drain("identity", 20);

    // Junk on diagonal/upper must be ignored; busy profile checked per cycle.
    @(negedge clk);
    L_in  = l2;
    start = 1'b1;
    e.x   = x2;
    e.acc = cyc + 1;
    sb.push_back(e);
    for (int k = 0; k <= LAT; k++) begin
      @(posedge clk);
      #2;
      start = 1'b0;
      chk($sformatf("busy_c%0d", k), NB'(busy),
          NB'((k >= 1 && k <= 7) ? 1 : 0));
    end
    drain("basic", 20);

    go(pk(8'd1, 8'd0, 8'h9C, 8'h00, 8'h64), x3, 1'b1);
    drain("narrow", 20);

    // Mid-run input change and restart request must be ignored.
    @(negedge clk);
    L_in  = pk(8'd1, 8'd0, 8'd1, 8'd1, 8'd1);
    start = 1'b1;
    e.x   = x6;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    L_in = l2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("restart_ignored", 20);
    repeat (6) @(negedge clk);

    // Asynchronous abort at cycle 4.
    go(l2, x2, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", NB'(busy), NB'(0));
    chk("abort_done", NB'(done), NB'(0));
    chk("abort_linv", Linv_out, id_m);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    go(l2, x2, 1'b1);
    drain("after_abort", 20);

    // Held start: back-to-back runs, DONE cycle ignores start.
    @(negedge clk);
    L_in  = pk(8'd1, 8'd0, 8'd1, 8'd1, 8'd1);
    start = 1'b1;
    t     = cyc;
    e.x   = x6;
    e.acc = t + 1;
    sb.push_back(e);
    e.acc = t + 11;
    sb.push_back(e);
    repeat (11) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drain("held_start", 30);
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
